regfile_wb_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle decode/register-file block.
- Holds the GPR array with a registered writeback stage and a selectable writeback source (ALU / memory / link).
- Adds read-after-write bypass from the writeback stage, selectable sign/zero immediate extension, and a load-pending scoreboard that raises a stall when a source register awaits memory data.
- Sits between instruction fetch/control and the ALU/memory stages.

---
 rtl/regfile_wb_scoreboard.sv | 138 +++++++++++++
 tb/tb_regfile_wb_scoreboard.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scoreboard.sv
// GPR file with a registered writeback stage, writeback-to-read bypass, immediate
// extension and a load-pending scoreboard that flags source-operand hazards.
module regfile_wb_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int IMM_WIDTH  = 16,
    parameter int LINK_REG   = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                instr,
    input  logic                       use_rs,
    input  logic                       use_rt,
    input  logic                       imm_zext,
    input  logic                       wb_en,
    input  logic [1:0]                 wb_sel,
    input  logic [1:0]                 reg_dst,
    input  logic [DATA_WIDTH-1:0]      alu_result,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic [DATA_WIDTH-1:0]      link_addr,
    input  logic                       load_issue,
    output logic [DATA_WIDTH-1:0]      rs_data,
    output logic [DATA_WIDTH-1:0]      rt_data,
    output logic [DATA_WIDTH-1:0]      imm_ext,
    output logic                       stall,
    output logic [(2**ADDR_WIDTH)-1:0] busy_mask
);
    localparam int REG_COUNT = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_LINK = 2'b10,
        DST_NONE = 2'b11
    } reg_dst_e;

    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [ADDR_WIDTH-1:0] rd;
    logic [IMM_WIDTH-1:0]  imm_raw;
    logic                  unused_instr_bits;

    assign rs                = instr[21 +: ADDR_WIDTH];
    assign rt                = instr[16 +: ADDR_WIDTH];
    assign rd                = instr[11 +: ADDR_WIDTH];
    assign imm_raw           = instr[IMM_WIDTH-1:0];
    assign unused_instr_bits = ^instr[31:26];

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q,  wb_addr_d;
    logic [DATA_WIDTH-1:0] wb_data_q,  wb_data_d;
    logic                  wb_is_mem_q, wb_is_mem_d;
    logic [DATA_WIDTH-1:0] imm_q,      imm_d;
    logic [REG_COUNT-1:0]  busy_q,     busy_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wb_addr_d = rt;
        case (reg_dst)
            DST_RT:   wb_addr_d = rt;
            DST_RD:   wb_addr_d = rd;
            DST_LINK: wb_addr_d = ADDR_WIDTH'(LINK_REG);
            default:  wb_addr_d = '0;
        endcase

        wb_data_d = alu_result;
        case (wb_sel)
            WB_ALU:  wb_data_d = alu_result;
            WB_MEM:  wb_data_d = mem_rdata;
            WB_LINK: wb_data_d = link_addr;
            default: wb_data_d = '0;
        endcase

        wb_valid_d  = wb_en && (wb_sel != WB_NONE) && (reg_dst != DST_NONE) && (wb_addr_d != '0);
        wb_is_mem_d = (wb_sel == WB_MEM);

        imm_d = imm_zext ? {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_raw}
                         : {{(DATA_WIDTH-IMM_WIDTH){imm_raw[IMM_WIDTH-1]}}, imm_raw};

        // Clear first, then set, so a new load to the retiring register keeps it busy.
        busy_d = busy_q;
        if (wb_valid_q && wb_is_mem_q) busy_d[wb_addr_q] = 1'b0;
        if (load_issue && (rt != '0))  busy_d[rt] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register array is cleared in reset because software may read a GPR before writing it.
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_is_mem_q <= 1'b0;
            imm_q       <= '0;
            busy_q      <= '0;
        end else begin
            if (wb_valid_q) regs_q[wb_addr_q] <= wb_data_q;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_is_mem_q <= wb_is_mem_d;
            imm_q       <= imm_d;
            busy_q      <= busy_d;
        end
    end

    logic wb_mem_hit_rs;
    logic wb_mem_hit_rt;

    always_comb begin
        if (rs == '0)                              rs_data = '0;
        else if (wb_valid_q && (wb_addr_q == rs))  rs_data = wb_data_q;
        else                                       rs_data = regs_q[rs];

        if (rt == '0)                              rt_data = '0;
        else if (wb_valid_q && (wb_addr_q == rt))  rt_data = wb_data_q;
        else                                       rt_data = regs_q[rt];

        // A load result sitting in the wb stage is already forwarded, so it no longer stalls.
        wb_mem_hit_rs = wb_valid_q && wb_is_mem_q && (wb_addr_q == rs);
        wb_mem_hit_rt = wb_valid_q && wb_is_mem_q && (wb_addr_q == rt);
        stall = (use_rs && (rs != '0) && busy_q[rs] && !wb_mem_hit_rs) ||
                (use_rt && (rt != '0) && busy_q[rt] && !wb_mem_hit_rt);
    end

    assign imm_ext   = imm_q;
    assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed and randomized checks of regfile_wb_scoreboard against a queue-based
// reference model of writes in flight, register contents and pending loads.
module tb_regfile_wb_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        use_rs, use_rt, imm_zext, wb_en, load_issue;
    logic [1:0]  wb_sel, reg_dst;
    logic [31:0] alu_result, mem_rdata, link_addr;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic        stall;
    logic [31:0] busy_mask;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .use_rs     (use_rs),
        .use_rt     (use_rt),
        .imm_zext   (imm_zext),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .reg_dst    (reg_dst),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .link_addr  (link_addr),
        .load_issue (load_issue),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm_ext    (imm_ext),
        .stall      (stall),
        .busy_mask  (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a write requested at edge N becomes visible for reading
    // (via bypass) right after edge N and lands in the array at edge N+1.
    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        bit          is_mem;
    } wr_t;

    wr_t         inflight[$];
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] m_imm;

    function automatic logic [31:0] mk_instr(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                             input logic [4:0] rd_f);
        return {6'b0, rs_f, rt_f, rd_f, 11'b0};
    endfunction

    task automatic model_edge();
        int unsigned dest;
        logic [31:0] src;
        bit          ok;
        wr_t         w;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            inflight.delete();
            m_imm = '0;
            return;
        end
        while (inflight.size() > 0) begin
            w = inflight.pop_front();
            m_regs[w.addr] = w.data;
            if (w.is_mem) m_busy[w.addr] = 1'b0;
        end
        ok = 1'b1;
        dest = 0;
        src = '0;
        case (reg_dst)
            2'd0:    dest = instr[20:16];
            2'd1:    dest = instr[15:11];
            2'd2:    dest = 31;
            default: ok = 1'b0;
        endcase
        case (wb_sel)
            2'd0:    src = alu_result;
            2'd1:    src = mem_rdata;
            2'd2:    src = link_addr;
            default: ok = 1'b0;
        endcase
        if (wb_en && ok && dest != 0) inflight.push_back('{dest, src, wb_sel == 2'd1});
        if (load_issue && instr[20:16] != 5'd0) m_busy[instr[20:16]] = 1'b1;
        m_imm = imm_zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    endtask

    function automatic logic [31:0] exp_read(input int unsigned r);
        if (r == 0) return '0;
        foreach (inflight[i]) if (inflight[i].addr == r) return inflight[i].data;
        return m_regs[r];
    endfunction

    function automatic bit exp_waiting(input int unsigned r);
        if (r == 0 || !m_busy[r]) return 1'b0;
        foreach (inflight[i]) if (inflight[i].addr == r && inflight[i].is_mem) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        use_rs = 0; use_rt = 0; imm_zext = 0; wb_en = 0; load_issue = 0;
        wb_sel = 2'b00; reg_dst = 2'b00;
        alu_result = '0; mem_rdata = '0; link_addr = '0; instr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        instr = {6'b0, 5'd5, 5'd31, 16'h2801};
        wb_en = 1; wb_sel = 2'b00; reg_dst = 2'b01; alu_result = 32'hDEAD_BEEF;
        load_issue = 1; use_rs = 1; use_rt = 1;
        tick();
        tick();
        if (rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs: got %h want %h", rs_data, 32'h0); end
        n_tests++;
        if (rt_data !== 32'h0) begin n_fail++; $display("FAIL reset_rt: got %h want %h", rt_data, 32'h0); end
        n_tests++;
        if (busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); end
        n_tests++;
        if (imm_ext !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h want %h", imm_ext, 32'h0); end
        n_tests++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_tests++;
        idle_inputs();
        rst_n = 1;
        instr = mk_instr(5'd5, 5'd31, 5'd0);
        tick();
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_no_write: got rs=%h rt=%h want 0", rs_data, rt_data);
        end
        n_tests++;
    endtask

    task automatic test_alu_bypass();
        idle_inputs();
        instr = mk_instr(5'd5, 5'd0, 5'd5);
        wb_en = 1; wb_sel = 2'b00; reg_dst = 2'b01; alu_result = 32'h0000_1234;
        #1;
        if (rs_data !== 32'h0) begin n_fail++; $display("FAIL alu_before_edge: got %h want %h", rs_data, 32'h0); end
        n_tests++;
        tick();
        wb_en = 0;
        instr = mk_instr(5'd5, 5'd0, 5'd0);
        #1;
        if (rs_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_bypass: got %h want %h", rs_data, 32'h1234); end
        n_tests++;
        tick();
        if (rs_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_array: got %h want %h", rs_data, 32'h1234); end
        n_tests++;
    endtask

    task automatic test_link_and_r0();
        idle_inputs();
        instr = mk_instr(5'd31, 5'd0, 5'd0);
        wb_en = 1; wb_sel = 2'b10; reg_dst = 2'b10; link_addr = 32'h0040_0008;
        tick();
        wb_en = 0;
        tick();
        if (rs_data !== 32'h0040_0008) begin n_fail++; $display("FAIL link_r31: got %h want %h", rs_data, 32'h0040_0008); end
        n_tests++;
        instr = mk_instr(5'd0, 5'd0, 5'd0);
        wb_en = 1; wb_sel = 2'b00; reg_dst = 2'b01; alu_result = 32'hFFFF_FFFF;
        tick();
        wb_en = 0;
        #1;
        if (rs_data !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h want %h", rs_data, 32'h0); end
        n_tests++;
        tick();
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_fail++; $display("FAIL r0_array: got rs=%h rt=%h want 0", rs_data, rt_data);
        end
        n_tests++;
    endtask

    task automatic test_immediate();
        idle_inputs();
        instr = 32'h0000_8001;
        imm_zext = 0;
        tick();
        if (imm_ext !== 32'hFFFF_8001) begin n_fail++; $display("FAIL imm_sext: got %h want %h", imm_ext, 32'hFFFF_8001); end
        n_tests++;
        imm_zext = 1;
        #1;
        if (imm_ext !== 32'hFFFF_8001) begin n_fail++; $display("FAIL imm_latency: got %h want %h", imm_ext, 32'hFFFF_8001); end
        n_tests++;
        tick();
        if (imm_ext !== 32'h0000_8001) begin n_fail++; $display("FAIL imm_zext: got %h want %h", imm_ext, 32'h0000_8001); end
        n_tests++;
    endtask

    task automatic test_load_hazard();
        idle_inputs();
        instr = mk_instr(5'd0, 5'd8, 5'd0);
        load_issue = 1;
        tick();
        load_issue = 0;
        instr = mk_instr(5'd8, 5'd0, 5'd0);
        use_rs = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall_%0d: got %b want 1", i, stall); end
            n_tests++;
            tick();
        end
        if (busy_mask !== 32'h0000_0100) begin n_fail++; $display("FAIL hazard_busy: got %h want %h", busy_mask, 32'h100); end
        n_tests++;
        instr = mk_instr(5'd8, 5'd8, 5'd0);
        wb_en = 1; wb_sel = 2'b01; reg_dst = 2'b00; mem_rdata = 32'h0000_CAFE;
        tick();
        wb_en = 0;
        #1;
        if (stall !== 1'b0 || rs_data !== 32'h0000_CAFE) begin
            n_fail++; $display("FAIL hazard_bypass: got stall=%b rs=%h want 0/%h", stall, rs_data, 32'hCAFE);
        end
        n_tests++;
        if (busy_mask !== 32'h0000_0100) begin n_fail++; $display("FAIL hazard_busy_held: got %h want %h", busy_mask, 32'h100); end
        n_tests++;
        tick();
        if (busy_mask !== 32'h0 || stall !== 1'b0 || rs_data !== 32'h0000_CAFE) begin
            n_fail++; $display("FAIL hazard_retired: got busy=%h stall=%b rs=%h want 0/0/%h", busy_mask, stall, rs_data, 32'hCAFE);
        end
        n_tests++;
    endtask

    task automatic test_set_clear_collision();
        idle_inputs();
        instr = mk_instr(5'd0, 5'd8, 5'd0);
        load_issue = 1;
        tick();
        load_issue = 0;
        wb_en = 1; wb_sel = 2'b01; reg_dst = 2'b00; mem_rdata = 32'h0000_BEEF;
        tick();
        wb_en = 0;
        load_issue = 1;
        instr = mk_instr(5'd8, 5'd8, 5'd0);
        use_rs = 1;
        #1;
        if (stall !== 1'b0 || rs_data !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL collide_bypass: got stall=%b rs=%h want 0/%h", stall, rs_data, 32'hBEEF);
        end
        n_tests++;
        tick();
        load_issue = 0;
        #1;
        if (busy_mask !== 32'h0000_0100 || stall !== 1'b1) begin
            n_fail++; $display("FAIL collide_set_wins: got busy=%h stall=%b want %h/1", busy_mask, stall, 32'h100);
        end
        n_tests++;
        if (rs_data !== 32'h0000_BEEF) begin n_fail++; $display("FAIL collide_data: got %h want %h", rs_data, 32'hBEEF); end
        n_tests++;
    endtask

    task automatic test_reset_mid_load();
        use_rs = 1;
        instr = mk_instr(5'd8, 5'd0, 5'd0);
        rst_n = 0;
        tick();
        if (busy_mask !== 32'h0 || stall !== 1'b0 || rs_data !== 32'h0) begin
            n_fail++; $display("FAIL midload_reset: got busy=%h stall=%b rs=%h want 0/0/0", busy_mask, stall, rs_data);
        end
        n_tests++;
        rst_n = 1;
        tick();
        if (busy_mask !== 32'h0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL midload_after: got busy=%h stall=%b want 0/0", busy_mask, stall);
        end
        n_tests++;
        idle_inputs();
    endtask

    task automatic test_random(input int cycles);
        logic [31:0] e_rs, e_rt, e_mask;
        bit          e_stall;
        for (int c = 0; c < cycles; c++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            instr      = $urandom;
            instr[25:21] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            instr[20:16] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            instr[15:11] = 5'($urandom_range(0, 7));
            use_rs     = 1'($urandom);
            use_rt     = 1'($urandom);
            imm_zext   = 1'($urandom);
            wb_en      = ($urandom_range(0, 3) != 0);
            wb_sel     = 2'($urandom);
            reg_dst    = 2'($urandom);
            alu_result = $urandom;
            mem_rdata  = $urandom;
            link_addr  = $urandom;
            load_issue = ($urandom_range(0, 3) == 0);
            #1;
            e_rs    = exp_read(instr[25:21]);
            e_rt    = exp_read(instr[20:16]);
            e_stall = (use_rs && exp_waiting(instr[25:21])) || (use_rt && exp_waiting(instr[20:16]));
            e_mask  = exp_mask();
            if (rs_data !== e_rs) begin n_fail++; $display("FAIL rand_rs[%0d]: got %h want %h", c, rs_data, e_rs); end
            n_tests++;
            if (rt_data !== e_rt) begin n_fail++; $display("FAIL rand_rt[%0d]: got %h want %h", c, rt_data, e_rt); end
            n_tests++;
            if (stall !== e_stall) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", c, stall, e_stall); end
            n_tests++;
            if (busy_mask !== e_mask) begin n_fail++; $display("FAIL rand_busy[%0d]: got %h want %h", c, busy_mask, e_mask); end
            n_tests++;
            if (imm_ext !== m_imm) begin n_fail++; $display("FAIL rand_imm[%0d]: got %h want %h", c, imm_ext, m_imm); end
            n_tests++;
            tick();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #2;
        test_reset();
        test_alu_bypass();
        test_link_and_r0();
        test_immediate();
        test_load_hazard();
        test_set_clear_collision();
        test_reset_mid_load();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
